// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Decode stage of the ARM pipeline with the ID/EX pipeline register folded in.
// It decodes one instruction per cycle, reads both operands from a register
// file (with write-back bypass), evaluates the condition code, detects RAW
// hazards against the instructions in EX/MEM, and registers the execute-stage
// controls and operands. It never holds: on a stall it loads a bubble and
// IF/ID re-presents the instruction.
//
// Build option:
//   ID_FWD_EN  defined   -> execute stage forwards; only load-use stalls
//              undefined -> any RAW dependency on EX/MEM stalls until write-back
//
// Ports:
//   clk, rst (async, active-low)
//   instr_valid, instr, pc_in, status_in {N,Z,C,V}, flush
//   wb_en / wb_dest / wb_value        register-file write port (bypassed)
//   exe_wb_en / exe_mem_r_en / exe_dest, mem_wb_en / mem_dest   hazard inputs
//   hazard_out                         combinational stall request
//   valid_out, pc_out, val_rn, val_rm, exe_cmd, s_out, b_out, mem_r_en,
//   mem_w_en, wb_en_out, imm_out, dest_out, src1_out, src2_out,
//   shift_operand, imm24               registered ID/EX contents
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int N       = 32,
  parameter int REG_NUM = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [31:0]   instr,
  input  logic [N-1:0]  pc_in,
  input  logic [3:0]    status_in,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [3:0]    wb_dest,
  input  logic [N-1:0]  wb_value,
  input  logic          exe_wb_en,
  input  logic          exe_mem_r_en,
  input  logic [3:0]    exe_dest,
  input  logic          mem_wb_en,
  input  logic [3:0]    mem_dest,
  output logic          hazard_out,
  output logic          valid_out,
  output logic [N-1:0]  pc_out,
  output logic [N-1:0]  val_rn,
  output logic [N-1:0]  val_rm,
  output logic [3:0]    exe_cmd,
  output logic          s_out,
  output logic          b_out,
  output logic          mem_r_en,
  output logic          mem_w_en,
  output logic          wb_en_out,
  output logic          imm_out,
  output logic [3:0]    dest_out,
  output logic [3:0]    src1_out,
  output logic [3:0]    src2_out,
  output logic [11:0]   shift_operand,
  output logic [23:0]   imm24
);

  localparam logic [4:0] LP_REG_NUM = 5'(REG_NUM);

  // Instruction fields
  logic [3:0] w_cond, w_op, w_rn, w_rd, w_rm, w_src2;
  logic [1:0] w_mode;
  logic       w_i, w_s;
  assign w_cond = instr[31:28];
  assign w_mode = instr[27:26];
  assign w_i    = instr[25];
  assign w_op   = instr[24:21];
  assign w_s    = instr[20];
  assign w_rn   = instr[19:16];
  assign w_rd   = instr[15:12];
  assign w_rm   = instr[3:0];

  // ---------------- decode ----------------
  logic [3:0] w_exe;
  logic       w_known, w_s_dec, w_b_dec, w_mr_dec, w_mw_dec, w_wb_dec, w_imm_dec;
  always_comb begin
    w_exe     = 4'b0000;
    w_known   = 1'b0;
    w_s_dec   = 1'b0;
    w_b_dec   = 1'b0;
    w_mr_dec  = 1'b0;
    w_mw_dec  = 1'b0;
    w_wb_dec  = 1'b0;
    w_imm_dec = 1'b0;
    case (w_mode)
      2'b00: begin
        w_known  = 1'b1;
        w_wb_dec = 1'b1;
        case (w_op)
          4'b1101: w_exe = 4'b0001;                          // MOV
          4'b1111: w_exe = 4'b1001;                          // MVN
          4'b0100: w_exe = 4'b0010;                          // ADD
          4'b0101: w_exe = 4'b0011;                          // ADC
          4'b0010: w_exe = 4'b0100;                          // SUB
          4'b0110: w_exe = 4'b0101;                          // SBC
          4'b0000: w_exe = 4'b0110;                          // AND
          4'b1100: w_exe = 4'b0111;                          // ORR
          4'b0001: w_exe = 4'b1000;                          // EOR
          4'b1010: begin w_exe = 4'b0100; w_wb_dec = 1'b0; end  // CMP
          4'b1000: begin w_exe = 4'b0110; w_wb_dec = 1'b0; end  // TST
          default: begin w_known = 1'b0; w_wb_dec = 1'b0; end
        endcase
        // Unlisted data-processing opcodes keep every control at zero
        w_s_dec   = w_known & w_s;
        w_imm_dec = w_known & w_i;
      end
      2'b01: begin
        w_exe     = 4'b0010;
        w_imm_dec = w_i;
        w_mr_dec  = w_s;       // LDR
        w_wb_dec  = w_s;
        w_mw_dec  = ~w_s;      // STR
      end
      2'b10: w_b_dec = 1'b1;
      default: ;
    endcase
  end

  logic w_is_str, w_uses_src1, w_uses_src2;
  assign w_is_str    = (w_mode == 2'b01) && !w_s;
  assign w_src2      = w_is_str ? w_rd : w_rm;
  assign w_uses_src1 = (w_mode != 2'b10) &&
                       !((w_mode == 2'b00) && ((w_op == 4'b1101) || (w_op == 4'b1111)));
  assign w_uses_src2 = ((w_mode == 2'b00) && !w_i) || w_is_str;

  // ---------------- condition ----------------
  logic w_fn, w_fz, w_fc, w_fv, w_cond_ok;
  assign {w_fn, w_fz, w_fc, w_fv} = status_in;
  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ok = w_fz;
      4'b0001: w_cond_ok = !w_fz;
      4'b0010: w_cond_ok = w_fc;
      4'b0011: w_cond_ok = !w_fc;
      4'b0100: w_cond_ok = w_fn;
      4'b0101: w_cond_ok = !w_fn;
      4'b0110: w_cond_ok = w_fv;
      4'b0111: w_cond_ok = !w_fv;
      4'b1000: w_cond_ok = w_fc && !w_fz;
      4'b1001: w_cond_ok = !w_fc || w_fz;
      4'b1010: w_cond_ok = (w_fn == w_fv);
      4'b1011: w_cond_ok = (w_fn != w_fv);
      4'b1100: w_cond_ok = !w_fz && (w_fn == w_fv);
      4'b1101: w_cond_ok = w_fz || (w_fn != w_fv);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  // ---------------- hazard ----------------
`ifdef ID_FWD_EN
  // Only a load in EX cannot be forwarded in time
  function automatic logic f_match(input logic [3:0] r);
    return exe_wb_en && exe_mem_r_en && (exe_dest == r);
  endfunction
  logic w_unused;
  assign w_unused = ^{mem_wb_en, mem_dest};
`else
  function automatic logic f_match(input logic [3:0] r);
    return (exe_wb_en && (exe_dest == r)) || (mem_wb_en && (mem_dest == r));
  endfunction
  logic w_unused;
  assign w_unused = exe_mem_r_en;
`endif

  assign hazard_out = instr_valid &&
                      ((w_uses_src1 && f_match(w_rn)) || (w_uses_src2 && f_match(w_src2)));

  // ---------------- register file ----------------
  logic [N-1:0] r_rf [REG_NUM];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) r_rf[i] <= '0;
    end else if (wb_en && ({1'b0, wb_dest} < LP_REG_NUM)) begin
      r_rf[wb_dest] <= wb_value;
    end
  end

  // Same-cycle write-back is visible to the read (bypass)
  function automatic logic [N-1:0] f_read(input logic [3:0] a);
    if ({1'b0, a} >= LP_REG_NUM)   return '0;
    else if (wb_en && wb_dest == a) return wb_value;
    else                            return r_rf[a];
  endfunction

  logic [N-1:0] w_val_rn, w_val_rm;
  assign w_val_rn = f_read(w_rn);
  assign w_val_rm = f_read(w_src2);

  // Flush, stall, invalid slot and failed condition all collapse to a bubble
  logic w_issue;
  assign w_issue = !flush && !hazard_out && instr_valid && w_cond_ok;

  // ---------------- ID/EX register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out     <= 1'b0;
      pc_out        <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      exe_cmd       <= 4'b0000;
      s_out         <= 1'b0;
      b_out         <= 1'b0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      wb_en_out     <= 1'b0;
      imm_out       <= 1'b0;
      dest_out      <= 4'b0000;
      src1_out      <= 4'b0000;
      src2_out      <= 4'b0000;
      shift_operand <= 12'h000;
      imm24         <= 24'h000000;
    end else begin
      pc_out        <= pc_in;
      val_rn        <= w_val_rn;
      val_rm        <= w_val_rm;
      dest_out      <= w_rd;
      src1_out      <= w_rn;
      src2_out      <= w_src2;
      shift_operand <= instr[11:0];
      imm24         <= instr[23:0];
      valid_out     <= w_issue;
      exe_cmd       <= w_issue ? w_exe : 4'b0000;
      s_out         <= w_issue && w_s_dec;
      b_out         <= w_issue && w_b_dec;
      mem_r_en      <= w_issue && w_mr_dec;
      mem_w_en      <= w_issue && w_mw_dec;
      wb_en_out     <= w_issue && w_wb_dec;
      imm_out       <= w_issue && w_imm_dec;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr = '0;
  logic [N-1:0]  pc_in = '0;
  logic [3:0]    status_in = '0;
  logic          flush = 1'b0;
  logic          wb_en = 1'b0;
  logic [3:0]    wb_dest = '0;
  logic [N-1:0]  wb_value = '0;
  logic          exe_wb_en = 1'b0, exe_mem_r_en = 1'b0, mem_wb_en = 1'b0;
  logic [3:0]    exe_dest = '0, mem_dest = '0;
  logic          hazard_out, valid_out;
  logic [N-1:0]  pc_out, val_rn, val_rm;
  logic [3:0]    exe_cmd, dest_out, src1_out, src2_out;
  logic          s_out, b_out, mem_r_en, mem_w_en, wb_en_out, imm_out;
  logic [11:0]   shift_operand;
  logic [23:0]   imm24;

  id_stage_pipe #(.N(N), .REG_NUM(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc_in(pc_in),
    .status_in(status_in), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .hazard_out(hazard_out), .valid_out(valid_out), .pc_out(pc_out),
    .val_rn(val_rn), .val_rm(val_rm), .exe_cmd(exe_cmd), .s_out(s_out),
    .b_out(b_out), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_out(wb_en_out),
    .imm_out(imm_out), .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .shift_operand(shift_operand), .imm24(imm24)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] exe;
    logic s, b, mr, mw, wb, imm, u1, u2;
    logic [3:0] src2;
  } dec_t;

  logic [3:0]  alu_cmd [16];
  logic        alu_ok  [16];
  logic        alu_wr  [16];
  logic [31:0] m_rf    [16];

  task automatic set_alu(input logic [3:0] op, input logic [3:0] cmd, input logic wr);
    alu_cmd[op] = cmd;
    alu_ok[op]  = 1'b1;
    alu_wr[op]  = wr;
  endtask

  function automatic dec_t model_dec(input logic [31:0] ins);
    dec_t d;
    logic [1:0] mode;
    logic [3:0] op;
    d    = '0;
    mode = ins[27:26];
    op   = ins[24:21];
    if (mode == 2'd0 && alu_ok[op]) begin
      d.exe = alu_cmd[op]; d.wb = alu_wr[op]; d.s = ins[20]; d.imm = ins[25];
    end else if (mode == 2'd1) begin
      d.exe = 4'd2; d.imm = ins[25]; d.mr = ins[20]; d.wb = ins[20]; d.mw = !ins[20];
    end else if (mode == 2'd2) begin
      d.b = 1'b1;
    end
    d.src2 = (mode == 2'd1 && !ins[20]) ? ins[15:12] : ins[3:0];
    d.u1   = (mode != 2'd2) && !(mode == 2'd0 && (op == 4'hD || op == 4'hF));
    d.u2   = (mode == 2'd0 && !ins[25]) || (mode == 2'd1 && !ins[20]);
    return d;
  endfunction

  // ARM conditions come in pairs: odd codes are the negation of the even one
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] st);
    logic n, z, cy, v, r;
    {n, z, cy, v} = st;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  function automatic logic model_haz(input dec_t d);
    logic [3:0] deps[$];
    logic [3:0] prod[$];
    logic h;
    h = 1'b0;
    if (d.u1) deps.push_back(instr[19:16]);
    if (d.u2) deps.push_back(d.src2);
`ifdef ID_FWD_EN
    if (exe_wb_en && exe_mem_r_en) prod.push_back(exe_dest);
`else
    if (exe_wb_en) prod.push_back(exe_dest);
    if (mem_wb_en) prod.push_back(mem_dest);
`endif
    foreach (deps[i]) foreach (prod[j]) if (deps[i] == prod[j]) h = 1'b1;
    return instr_valid && h;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    return (wb_en && wb_dest == a) ? wb_value : m_rf[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already applied just after a rising edge
  task automatic step(input string tag);
    dec_t d;
    logic haz, iss;
    logic [31:0] e_rn, e_rm, e_pc, e_ins;
    #2;
    d     = model_dec(instr);
    haz   = model_haz(d);
    iss   = !flush && !haz && instr_valid && model_cond(instr[31:28], status_in);
    e_rn  = model_read(instr[19:16]);
    e_rm  = model_read(d.src2);
    e_pc  = pc_in;
    e_ins = instr;
    chk({tag, " hazard"}, 32'(hazard_out), 32'(haz));
    @(posedge clk);
    if (wb_en) m_rf[wb_dest] = wb_value;
    #1;
    $display("step %s: instr=%h valid_in=%0d flush=%0d haz=%0d issue=%0d", tag, e_ins, instr_valid, flush, haz, iss);
    chk({tag, " valid"},  32'(valid_out), 32'(iss));
    chk({tag, " exe"},    32'(exe_cmd),   32'(iss ? d.exe : 4'd0));
    chk({tag, " wb"},     32'(wb_en_out), 32'(iss && d.wb));
    chk({tag, " mr"},     32'(mem_r_en),  32'(iss && d.mr));
    chk({tag, " mw"},     32'(mem_w_en),  32'(iss && d.mw));
    chk({tag, " b"},      32'(b_out),     32'(iss && d.b));
    chk({tag, " s"},      32'(s_out),     32'(iss && d.s));
    chk({tag, " imm"},    32'(imm_out),   32'(iss && d.imm));
    if (iss) begin
      chk({tag, " pc"},    pc_out, e_pc);
      chk({tag, " rn"},    val_rn, e_rn);
      chk({tag, " rm"},    val_rm, e_rm);
      chk({tag, " dest"},  32'(dest_out), 32'(e_ins[15:12]));
      chk({tag, " src1"},  32'(src1_out), 32'(e_ins[19:16]));
      chk({tag, " src2"},  32'(src2_out), 32'(d.src2));
      chk({tag, " shop"},  32'(shift_operand), 32'(e_ins[11:0]));
      chk({tag, " imm24"}, 32'(imm24), 32'(e_ins[23:0]));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      alu_ok[i] = 1'b0; alu_cmd[i] = 4'd0; alu_wr[i] = 1'b0; m_rf[i] = 32'd0;
    end
    set_alu(4'hD, 4'h1, 1'b1); set_alu(4'hF, 4'h9, 1'b1); set_alu(4'h4, 4'h2, 1'b1);
    set_alu(4'h5, 4'h3, 1'b1); set_alu(4'h2, 4'h4, 1'b1); set_alu(4'h6, 4'h5, 1'b1);
    set_alu(4'h0, 4'h6, 1'b1); set_alu(4'hC, 4'h7, 1'b1); set_alu(4'h1, 4'h8, 1'b1);
    set_alu(4'hA, 4'h4, 1'b0); set_alu(4'h8, 4'h6, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(valid_out), 32'd0);
    chk("rst exe",   32'(exe_cmd),   32'd0);
    chk("rst wb",    32'(wb_en_out), 32'd0);
    chk("rst pc",    pc_out, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Write r2=5, r3=7 then ADD r1,r2,r3
    wb_en = 1; wb_dest = 4'd2; wb_value = 32'd5; step("wr_r2");
    wb_dest = 4'd3; wb_value = 32'd7; step("wr_r3");
    wb_en = 0; instr = 32'hE0821003; instr_valid = 1; pc_in = 32'h100; step("add");
    chk("add exe_lit",  32'(exe_cmd), 32'h2);
    chk("add wb_lit",   32'(wb_en_out), 32'd1);
    chk("add rn_lit",   val_rn, 32'd5);
    chk("add rm_lit",   val_rm, 32'd7);
    chk("add dest_lit", 32'(dest_out), 32'd1);
    chk("add valid_lit", 32'(valid_out), 32'd1);

    // Bypass of same-cycle write-back
    wb_en = 1; wb_dest = 4'd2; wb_value = 32'h1234; step("bypass");
    chk("bypass rn_lit", val_rn, 32'h1234);
    wb_en = 0;

    // Condition EQ
    instr = 32'h00821003; status_in = 4'b0000; step("addeq_f");
    chk("addeq_f valid_lit", 32'(valid_out), 32'd0);
    status_in = 4'b0100; step("addeq_t");
    chk("addeq_t valid_lit", 32'(valid_out), 32'd1);

    // Hazard on rn against EX
    instr = 32'hE0821003; exe_dest = 4'd2; exe_wb_en = 1; #1;
`ifdef ID_FWD_EN
    chk("haz_ex lit", 32'(hazard_out), 32'd0);
    step("haz_ex");
    exe_mem_r_en = 1; #1;
    chk("haz_ld lit", 32'(hazard_out), 32'd1);
    step("haz_ld");
`else
    chk("haz_ex lit", 32'(hazard_out), 32'd1);
    step("haz_ex");
    chk("haz_ex valid_lit", 32'(valid_out), 32'd0);
`endif
    exe_wb_en = 0; exe_mem_r_en = 0;

    // STR r4,[r1]
    instr = 32'hE5814000; step("str");
    chk("str src2_lit", 32'(src2_out), 32'd4);
    chk("str mw_lit",   32'(mem_w_en), 32'd1);
    chk("str wb_lit",   32'(wb_en_out), 32'd0);
    mem_wb_en = 1; mem_dest = 4'd4; #1;
`ifdef ID_FWD_EN
    chk("str_haz lit", 32'(hazard_out), 32'd0);
`else
    chk("str_haz lit", 32'(hazard_out), 32'd1);
`endif
    step("str_haz");
    mem_wb_en = 0;

    // Flush kills a clean ADD
    instr = 32'hE0821003; flush = 1; step("flush");
    chk("flush valid_lit", 32'(valid_out), 32'd0);
    flush = 0;

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic [3:0] cnd;
      cnd = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
      instr = {cnd, 2'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
               4'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 4'($urandom_range(0, 3))};
      instr_valid  = ($urandom_range(0, 7) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      status_in    = 4'($urandom);
      pc_in        = $urandom;
      wb_en        = 1'($urandom);
      wb_dest      = 4'($urandom_range(0, 5));
      wb_value     = $urandom;
      exe_wb_en    = 1'($urandom);
      exe_mem_r_en = 1'($urandom);
      exe_dest     = 4'($urandom_range(0, 5));
      mem_wb_en    = 1'($urandom);
      mem_dest     = 4'($urandom_range(0, 5));
      step("rnd");
    end

    // Asynchronous reset mid-stream
    wb_en = 0; flush = 0; exe_wb_en = 0; mem_wb_en = 0; instr_valid = 1;
    instr = 32'hE0821003; step("pre_rst");
    #2 rst = 1'b0;
    #1;
    chk("arst valid", 32'(valid_out), 32'd0);
    chk("arst exe",   32'(exe_cmd),   32'd0);
    chk("arst wb",    32'(wb_en_out), 32'd0);
    chk("arst rn",    val_rn, 32'd0);
    chk("arst pc",    pc_out, 32'd0);
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    step("post_rst");
    chk("post_rst rn_lit", val_rn, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
